uart_rx_oversample: RTL and testbench

//  Oversampling UART receiver; upstream stage that turns the raw i_RX_Serial pin into bytes for the WatchBase RX FIFO.

---
 rtl/uart_rx_oversample.sv | 146 ++++++++++++++
 tb/tb_uart_rx_oversample.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// Oversampling 8N1 UART receiver: 2-flop synchroniser, 1/OVERSAMPLE-bit sample grid,
// 3-sample majority vote per bit, one-clock strobes for data, framing error and line break.
//
// state    | meaning
// IDLE     | line idle, counters cleared, waiting for rx_s low
// START    | timing the start bit; a high vote rejects it as a glitch
// DATA     | shifting in WIDTH data bits, LSB first
// STOP     | deciding on the stop bit at its 3rd vote sample
// BRK_WAIT | stop bit was low; wait for the line to return high
module uart_rx_oversample #(
  parameter int FPGA_clk_freq = 50000000,
  parameter int baudrate      = 115200,
  parameter int WIDTH         = 8,
  parameter int OVERSAMPLE    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_RX_Serial,
  output logic [WIDTH-1:0] o_RX_Data,
  output logic             o_RX_DV,
  output logic             o_frame_err,
  output logic             o_break,
  output logic             o_busy
);

  localparam int TICK_DIV = FPGA_clk_freq / (baudrate * OVERSAMPLE);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [TW-1:0] T_END = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] S_V0  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_V1  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] S_V2  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] I_END = IW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;

  state_t           state, state_n;
  logic             rx_meta, rx_s;
  logic [TW-1:0]    tick_cnt;
  logic [SW-1:0]    s_cnt;
  logic [IW-1:0]    bit_idx;
  logic [2:0]       samp;
  logic [WIDTH-1:0] shift;
  logic             tick, bit_end, stop_pt, vote_end, vote_stop;
  logic             dv_n, fe_n, brk_n;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_s    <= rx_meta;
    end
  end

  assign tick      = (state != IDLE) && (state != BRK_WAIT) && (tick_cnt == T_END);
  assign bit_end   = tick && (s_cnt == S_END);
  assign stop_pt   = tick && (s_cnt == S_V2);
  assign vote_end  = maj3(samp[0], samp[1], samp[2]);
  // The stop decision uses the live 3rd sample so the FSM is back in IDLE before a gapless next start.
  assign vote_stop = maj3(samp[0], samp[1], rx_s);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (!rx_s) state_n = START;
      START:    if (bit_end) state_n = vote_end ? IDLE : DATA;
      DATA:     if (bit_end && (bit_idx == I_END)) state_n = STOP;
      STOP:     if (stop_pt) state_n = vote_stop ? IDLE : BRK_WAIT;
      BRK_WAIT: if (rx_s) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    dv_n  = 1'b0;
    fe_n  = 1'b0;
    brk_n = 1'b0;
    if (state == STOP && stop_pt) begin
      if (vote_stop)       dv_n  = 1'b1;
      else if (shift == '0) brk_n = 1'b1;
      else                 fe_n  = 1'b1;
    end
  end

  // Tick counter starts on the clock that leaves IDLE, so sample phase is referenced to the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      s_cnt    <= '0;
      bit_idx  <= '0;
      samp     <= '0;
      shift    <= '0;
    end else begin
      if (state_n == IDLE || state_n == BRK_WAIT) begin
        tick_cnt <= '0;
        s_cnt    <= '0;
      end else if (tick) begin
        tick_cnt <= '0;
        s_cnt    <= (s_cnt == S_END) ? '0 : s_cnt + SW'(1);
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end

      if (tick && s_cnt == S_V0) samp[0] <= rx_s;
      if (tick && s_cnt == S_V1) samp[1] <= rx_s;
      if (tick && s_cnt == S_V2) samp[2] <= rx_s;

      if (state == START && bit_end) bit_idx <= '0;
      if (state == DATA && bit_end) begin
        shift   <= {vote_end, shift[WIDTH-1:1]};
        bit_idx <= bit_idx + IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_RX_Data   <= '0;
      o_RX_DV     <= 1'b0;
      o_frame_err <= 1'b0;
      o_break     <= 1'b0;
    end else begin
      o_RX_DV     <= dv_n;
      o_frame_err <= fe_n;
      o_break     <= brk_n;
      if (dv_n) o_RX_Data <= shift;
    end
  end

  assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: serial frames driven in real time, expected events queued by the
// stimulus and popped by an independent strobe monitor. Runs at a faster baud to keep cycle count low.
`timescale 1ns/1ps
module tb_uart_rx_oversample;

  // 50 MHz clock, 390625 baud x16 -> 8 clk per tick, 128 clk (2560 ns) per bit.
  localparam int NOM_NS = 2560;
  localparam int BIT_NS = 2572;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       dv, fe, brk, busy;

  typedef struct {
    int         kind;   // 0 data, 1 frame error, 2 break
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_good = 8'h00;
  bit         prev_any = 1'b0;

  always #10 clk = ~clk;

  uart_rx_oversample #(
    .FPGA_clk_freq(50000000),
    .baudrate     (390625),
    .WIDTH        (8),
    .OVERSAMPLE   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_RX_Serial(rx),
    .o_RX_Data  (rx_data),
    .o_RX_DV    (dv),
    .o_frame_err(fe),
    .o_break    (brk),
    .o_busy     (busy)
  );

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int kind, input logic [7:0] d);
    exp_t e;
    e.kind = kind;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // A frame whose stop bit is low reports a break if all data bits are 0, else a framing error.
  task automatic send_frame(input logic [7:0] d, input int bit_ns, input bit stop_ok, input bit expect_it);
    if (expect_it) push_exp(stop_ok ? 0 : ((d == 8'h00) ? 2 : 1), d);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop_ok;
    #(bit_ns);
    rx = 1'b1;
  endtask

  always @(negedge clk) begin
    int   act_kind;
    exp_t e;
    if (rst) last_good = 8'h00;
    if (!rst && (dv || fe || brk)) begin
      check("strobe_onehot", $countones({dv, fe, brk}), 1);
      check("strobe_back_to_back", int'(prev_any), 0);
      act_kind = dv ? 0 : (fe ? 1 : 2);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", act_kind, -1);
      end else begin
        e = exp_q.pop_front();
        check("strobe_kind", act_kind, e.kind);
        if (e.kind == 0) begin
          check("rx_data", int'(rx_data), int'(e.data));
          last_good = e.data;
        end else begin
          check("rx_data_held", int'(rx_data), int'(last_good));
        end
      end
    end
    prev_any = !rst && (dv || fe || brk);
  end

  initial begin
    logic [7:0] d;
    int         bn;
    bit         ok;

    rx  = 1'b1;
    rst = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_data", int'(rx_data), 0);
    check("rst_dv", int'(dv), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", int'(busy), 0);
    check("idle_strobes", int'({dv, fe, brk}), 0);

    // single byte
    send_frame(8'h37, BIT_NS, 1'b1, 1'b1);
    #(BIT_NS);

    // gapless burst
    send_frame(8'h37, BIT_NS, 1'b1, 1'b1);
    send_frame(8'h38, BIT_NS, 1'b1, 1'b1);
    send_frame(8'h39, BIT_NS, 1'b1, 1'b1);
    send_frame(8'h40, BIT_NS, 1'b1, 1'b1);
    #(BIT_NS);

    // short low glitch
    rx = 1'b0;
    #300;
    check("glitch_busy_high", int'(busy), 1);
    #290;
    rx = 1'b1;
    #(NOM_NS + 200);
    check("glitch_busy_low", int'(busy), 0);
    #(BIT_NS);

    // framing error then recovery
    send_frame(8'h55, BIT_NS, 1'b0, 1'b1);
    #(BIT_NS);
    send_frame(8'hA5, BIT_NS, 1'b1, 1'b1);
    #(BIT_NS);

    // long break then recovery
    push_exp(2, 8'h00);
    rx = 1'b0;
    #(20 * BIT_NS);
    check("break_busy_held", int'(busy), 1);
    rx = 1'b1;
    #(BIT_NS);
    check("break_busy_released", int'(busy), 0);
    send_frame(8'h12, BIT_NS, 1'b1, 1'b1);
    #(BIT_NS);

    // reset mid-frame; reset is held to the end of the frame so its tail is not seen as a new start
    fork
      send_frame(8'hC3, BIT_NS, 1'b1, 1'b0);
      begin
        #(5 * BIT_NS + BIT_NS / 2);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_data", int'(rx_data), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_strobes", int'({dv, fe, brk}), 0);
        #(5 * BIT_NS);
        rst = 1'b0;
      end
    join
    #(BIT_NS);
    send_frame(8'h3C, BIT_NS, 1'b1, 1'b1);
    #(BIT_NS);

    // randomized frames: byte, baud error within about +/-2.4%, stop bit quality, idle gap
    for (int n = 0; n < 16; n++) begin
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      bn = $urandom_range(2500, 2620);
      ok = ($urandom_range(0, 4) != 0);
      send_frame(d, bn, ok, 1'b1);
      if (!ok) #(bn + $urandom_range(0, bn));
      else if ($urandom_range(0, 1) == 1) #($urandom_range(0, 2 * bn));
    end

    #(2 * NOM_NS);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
